// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl
// Four-requester round-robin arbiter sharing one resource slot.
// The grant is registered and one-hot. Every release is followed by one idle
// cycle before the next grant can be issued.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a hold counter forces a release after HOLD_MAX cycles of
//   grant, and timeout_o pulses for the first idle cycle after that release.
//   When undefined, grants are unbounded and timeout_o is tied to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i[3:0]   request vector, bit i = requester i
//   done_i       current owner releases the grant (ignored while idle)
//   gnt_o[3:0]   one-hot grant, zero when idle
//   gnt_id_o     index of current/last granted requester
//   gnt_valid_o  a grant is active
//   timeout_o    one-cycle pulse after a forced release
//
// state  | meaning
// IDLE   | no grant; picks a winner from req_i starting at ptr
// GRANT  | gnt_id owns the slot until done, request drop or hold limit
module rr_arb4_ctrl #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_id_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gnt_id_q;
  logic [3:0] gnt_q;
  logic       gnt_valid_q;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       nat_rel;
  logic       force_rel;

  // Rotating scan: ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign nat_rel = done_i || !req_i[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  // Counter is 0 in the first grant cycle, so HOLD_MAX-1 marks the last one.
  assign force_rel = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == S_IDLE) begin
        hold_cnt_q <= '0;
      end else if (nat_rel || force_rel) begin
        hold_cnt_q <= '0;
        // A natural release on the limit cycle is not reported as a timeout.
        timeout_q  <= !nat_rel;
      end else begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      gnt_id_q    <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q     <= S_GRANT;
            gnt_id_q    <= win_idx;
            gnt_q       <= 4'b0001 << win_idx;
            gnt_valid_q <= 1'b1;
          end
        end
        S_GRANT: begin
          // done and request drop together still advance the pointer once.
          if (nat_rel || force_rel) begin
            state_q     <= S_IDLE;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_id_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
module tb_rr_arb4_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD = 4;
`else
  localparam int unsigned HOLD = 15;
`endif

  rr_arb4_ctrl #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id),
    .gnt_valid_o(gnt_valid),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
    check({tag, "_valid"}, 32'(gnt_valid), 32'(v));
  endtask

  // Structural invariant: grant must always equal the decode of gnt_id when valid.
  always @(negedge clk) begin
    check("inv_onehot", 32'(gnt), gnt_valid ? (32'd1 << gnt_id) : 32'd0);
  end

  int exp_seq[4] = '{1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    chk_gnt("reset", 4'b0000, 2'd0, 1'b0);
    check("reset_timeout", 32'(timeout), 32'd0);

    // Grant requester 2, then reset mid-cycle.
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    chk_gnt("pre_reset", 4'b0100, 2'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_gnt("async_reset", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001;
    #1 rst_n = 1'b1;
    tick();
    chk_gnt("post_reset", 4'b0001, 2'd0, 1'b1);

    // Single requester: hold, release with done, regrant after dead cycle.
    tick();
    chk_gnt("single_hold", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    tick();
    chk_gnt("single_rel", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    tick();
    chk_gnt("single_regnt", 4'b0001, 2'd0, 1'b1);

    // Fairness: all requesting, done each grant -> 1,2,3,0 with a gap each time.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      done = 1'b1;
      tick();
      chk_gnt("fair_gap", 4'b0000, exp_seq[(i + 3) % 4][1:0], 1'b0);
      done = 1'b0;
      tick();
      chk_gnt("fair_gnt", 4'(1 << exp_seq[i]), exp_seq[i][1:0], 1'b1);
    end

    // Pointer: serve 1 (ptr->2), then req 0011 -> 0, then 1.
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0010;
    tick();
    chk_gnt("ptr_serve1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    req  = 4'b0011;
    tick();
    done = 1'b0;
    tick();
    chk_gnt("ptr_wrap0", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk_gnt("ptr_next1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick();

    // done while idle has no effect; gnt_id holds last value.
    req  = 4'b0000;
    done = 1'b1;
    tick();
    chk_gnt("idle_done", 4'b0000, 2'd1, 1'b0);
    done = 1'b0;

    // Simultaneous done and request drop: one release, ptr becomes 3.
    req = 4'b0100;
    tick();
    chk_gnt("sim_gnt2", 4'b0100, 2'd2, 1'b1);
    done = 1'b1;
    req  = 4'b1000;
    tick();
    chk_gnt("sim_rel", 4'b0000, 2'd2, 1'b0);
    done = 1'b0;
    req  = 4'b1100;
    tick();
    chk_gnt("sim_next3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();
    chk_gnt("drop_rel", 4'b0000, 2'd3, 1'b0);
    tick();

    // Hold-limit behaviour with req 0110 and no done (ptr is 0).
    req = 4'b0110;
    tick();
    chk_gnt("to_start", 4'b0010, 2'd1, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_gnt("to_hold", 4'b0010, 2'd1, 1'b1);
      check("to_hold_pulse", 32'(timeout), 32'd0);
    end
    tick();
    chk_gnt("to_release", 4'b0000, 2'd1, 1'b0);
    check("to_pulse", 32'(timeout), 32'd1);
    tick();
    chk_gnt("to_next2", 4'b0100, 2'd2, 1'b1);
    check("to_pulse_end", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check("nto_hold", 32'(gnt), 32'b0010);
      check("nto_timeout", 32'(timeout), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb4_ctrl.md
Name: rr_arb4_ctrl

Overview:
- Four-requester round-robin arbiter sharing one resource slot.
- Grant output is a registered one-hot, produced by a 2-to-4 decode of the winning index.
- Sits in front of any shared dataflow unit; requesters hold `req` until served, then pulse `done`.
- Grants are mutually exclusive. Every grant-to-grant transition has one dead cycle.

Parameters:
- HOLD_MAX, 15, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i = requester i.
- done  input  1  current owner releases grant; sampled only while gnt_valid=1.
- gnt  output  4  one-hot grant; all zero when idle.
- gnt_id  output  2  index of current/last granted requester.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous, overrides everything, including mid-grant):
  - gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0.
  - Priority pointer ptr=0; state=IDLE; hold counter=0.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE; outputs unchanged (gnt=0, gnt_valid=0, gnt_id holds last value).
  - If req!=0, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - At the next edge: gnt_id=winner, gnt=1<<winner, gnt_valid=1, state=GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT:
  - Grant holds while req[gnt_id]=1 and done=0.
  - Requests from other bits are ignored; they stay pending, nothing is latched.
  - Release condition: done=1, or req[gnt_id]=0, or (with ARB_TIMEOUT_EN) hold count reached.
  - On the release edge:
    - gnt becomes 0 and gnt_valid becomes 0; state=IDLE.
    - ptr=gnt_id+1 mod 4 (3 wraps to 0); gnt_id keeps its value.
  - Simultaneous done=1 and req[gnt_id]=0 count as a single release; no double pointer advance.
- The dead cycle (one IDLE cycle) between successive grants is mandatory, even when requests are pending. Back-to-back grants therefore have a 2-cycle period minimum.
- done while gnt_valid=0 has no effect.
- Pointer wrap-around: after serving 3, requester 0 has highest priority.
- A requester that re-asserts after release can win again only if no higher-rotation request is present.
- Invariants:
  - gnt is always 0 or exactly one-hot.
  - gnt==(gnt_valid ? 1<<gnt_id : 0) at all times.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant entry and increments each cycle in GRANT.
  - When gnt_valid has been high for HOLD_MAX cycles without another release condition, a forced release occurs at the next edge, with the normal pointer update.
  - timeout=1 for exactly the first IDLE cycle after a forced release.
  - A natural release takes precedence when it coincides with the limit: timeout stays 0.
- Undefined:
  - No counter logic is present; timeout is tied to 0.
  - Grants are unbounded.

Test Plan:
- Reset: req=4'b0100 granted (gnt=4'b0100), then assert rst_n=0 mid-cycle -> gnt=0, gnt_valid=0 immediately, without waiting for a clock edge. Release reset with req=4'b0001 -> gnt=4'b0001, gnt_id=0 one edge later.
- Single requester: req=4'b0001 at edge 0 -> gnt=4'b0001 at edge 1. done pulse at edge 3 -> gnt=0 at edge 4. Continued req -> gnt=4'b0001 again at edge 5.
- Fairness: req=4'b1111 held, done pulsed in each grant cycle -> gnt_id sequence 0,1,2,3,0, with gnt=0 for one cycle between each.
- Wrap/pointer: serve requester 1 (ptr becomes 2), then req=4'b0011 -> winner 0, not 1. Next grant with req=4'b0011 still held -> 1.
- Simultaneous release: in GRANT of id 2, drive done=1 and req[2]=0 together -> one release, ptr=3. Then req=4'b1100 -> gnt_id=3.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req=4'b0110 held, no done.
  - gnt=4'b0010 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=4'b0100.
  - Without the macro, gnt=4'b0010 persists for 100+ cycles and timeout stays 0.
